mem_bus_guard: RTL and testbench

Registered bus stage between the picorv32 memory port and the top-level address decode/response mux. It captures each CPU memory request and re-issues it on the downstream bus. It returns the downstream response to the CPU. If a target never asserts ready, it terminates the access with a fixed read value, which is the illegal instruction for fetches, so the CPU traps. Timeouts are counted and the failing address is logged for the tk1 core to read.

---
 rtl/mem_bus_guard.sv | 153 +++++++++++++++
 tb/tb_mem_bus_guard.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_guard.sv
// Registered bus stage between the CPU memory port and the decode/response mux.
// Terminates accesses whose target never responds and logs the failing address.
module mem_bus_guard #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic        cpu_instr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        bus_valid,
  output logic        bus_instr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        err_clear,
  output logic        timeout_event,
  output logic [7:0]  err_count,
  output logic [31:0] err_addr,
  output logic        err_instr
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [15:0] TimerLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        bus_valid_q, bus_valid_d;
  logic        bus_instr_q, bus_instr_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic        timeout_event_q, timeout_event_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        err_instr_q, err_instr_d;

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    cpu_ready_d     = 1'b0;
    cpu_rdata_d     = cpu_rdata_q;
    bus_valid_d     = bus_valid_q;
    bus_instr_d     = bus_instr_q;
    bus_addr_d      = bus_addr_q;
    bus_wdata_d     = bus_wdata_q;
    bus_wstrb_d     = bus_wstrb_q;
    timeout_event_d = 1'b0;
    err_count_d     = err_count_q;
    err_addr_d      = err_addr_q;
    err_instr_d     = err_instr_q;

    // Clear first so a coincident timeout is logged on top of the cleared values.
    if (err_clear) begin
      err_count_d = 8'h00;
      err_addr_d  = 32'h0;
    end

    unique case (state_q)
      StIdle: begin
        if (cpu_valid && !cpu_ready_q) begin
          bus_instr_d = cpu_instr;
          bus_addr_d  = cpu_addr;
          bus_wdata_d = cpu_wdata;
          bus_wstrb_d = cpu_wstrb;
          bus_valid_d = 1'b1;
          timer_d     = 16'h0;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (bus_ready) begin
          cpu_rdata_d = bus_rdata;
          cpu_ready_d = 1'b1;
          bus_valid_d = 1'b0;
          state_d     = StResp;
        end else if (timer_q == TimerLast) begin
          cpu_rdata_d     = TIMEOUT_RDATA;
          cpu_ready_d     = 1'b1;
          bus_valid_d     = 1'b0;
          timeout_event_d = 1'b1;
          err_addr_d      = bus_addr_q;
          err_instr_d     = bus_instr_q;
          err_count_d     = (err_count_d == 8'hff) ? 8'hff : err_count_d + 8'h01;
          state_d         = StResp;
        end else begin
          timer_d = timer_q + 16'h1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      timer_q         <= 16'h0;
      cpu_ready_q     <= 1'b0;
      cpu_rdata_q     <= 32'h0;
      bus_valid_q     <= 1'b0;
      bus_instr_q     <= 1'b0;
      bus_addr_q      <= 32'h0;
      bus_wdata_q     <= 32'h0;
      bus_wstrb_q     <= 4'h0;
      timeout_event_q <= 1'b0;
      err_count_q     <= 8'h00;
      err_addr_q      <= 32'h0;
      err_instr_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      cpu_ready_q     <= cpu_ready_d;
      cpu_rdata_q     <= cpu_rdata_d;
      bus_valid_q     <= bus_valid_d;
      bus_instr_q     <= bus_instr_d;
      bus_addr_q      <= bus_addr_d;
      bus_wdata_q     <= bus_wdata_d;
      bus_wstrb_q     <= bus_wstrb_d;
      timeout_event_q <= timeout_event_d;
      err_count_q     <= err_count_d;
      err_addr_q      <= err_addr_d;
      err_instr_q     <= err_instr_d;
    end
  end

  assign cpu_ready     = cpu_ready_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign bus_valid     = bus_valid_q;
  assign bus_instr     = bus_instr_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_wstrb     = bus_wstrb_q;
  assign timeout_event = timeout_event_q;
  assign err_count     = err_count_q;
  assign err_addr      = err_addr_q;
  assign err_instr     = err_instr_q;

endmodule

// File: tb/tb_mem_bus_guard.sv
// Directed bench for mem_bus_guard; responses are checked against a scoreboard queue.
module tb_mem_bus_guard;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_valid, cpu_instr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        bus_valid, bus_instr;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        err_clear;
  logic        timeout_event;
  logic [7:0]  err_count;
  logic [31:0] err_addr;
  logic        err_instr;

  typedef struct packed {
    logic [31:0] rdata;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_bus_guard #(
    .TIMEOUT_CYCLES(T),
    .TIMEOUT_RDATA (32'h0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_valid    (cpu_valid),
    .cpu_instr    (cpu_instr),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_wstrb    (cpu_wstrb),
    .cpu_ready    (cpu_ready),
    .cpu_rdata    (cpu_rdata),
    .bus_valid    (bus_valid),
    .bus_instr    (bus_instr),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_ready    (bus_ready),
    .bus_rdata    (bus_rdata),
    .err_clear    (err_clear),
    .timeout_event(timeout_event),
    .err_count    (err_count),
    .err_addr     (err_addr),
    .err_instr    (err_instr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Every cpu_ready cycle must consume exactly one pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (cpu_ready === 1'b1) begin
      check("resp_pending", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("resp_rdata", cpu_rdata, e.rdata);
        check("resp_timeout_event", 32'(timeout_event), 32'(e.tmo));
      end
    end
  end

  // ready_at: edge after capture at which bus_ready is sampled (0 = never).
  task automatic access(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int ready_at, input logic [31:0] rdata,
                        input int clr_at);
    bit   tmo;
    int   exp_k;
    int   got;
    exp_t e;
    tmo   = !(ready_at > 0 && ready_at <= int'(T));
    exp_k = tmo ? int'(T) : ready_at;
    got   = 0;
    e.rdata = tmo ? 32'h0 : rdata;
    e.tmo   = tmo;
    cpu_valid = 1'b1;
    cpu_instr = instr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_wstrb = wstrb;
    sb.push_back(e);
    @(posedge clk); #1;
    check("bus_valid_rise", 32'(bus_valid), 32'd1);
    check("bus_addr", bus_addr, addr);
    check("bus_wdata", bus_wdata, wdata);
    check("bus_wstrb", 32'(bus_wstrb), 32'(wstrb));
    check("bus_instr", 32'(bus_instr), 32'(instr));
    cpu_valid = 1'b0;
    cpu_instr = ~instr;
    cpu_addr  = ~addr;
    cpu_wdata = ~wdata;
    cpu_wstrb = ~wstrb;
    for (int k = 1; k <= int'(T); k++) begin
      bus_ready = (k == ready_at);
      bus_rdata = (k == ready_at) ? rdata : (32'hbad0_0000 | 32'(k));
      err_clear = (k == clr_at);
      @(posedge clk); #1;
      bus_ready = 1'b0;
      err_clear = 1'b0;
      if (cpu_ready === 1'b1) begin
        got = k;
        break;
      end
    end
    check("resp_latency", 32'(got), 32'(exp_k));
    check("bus_valid_drop", 32'(bus_valid), 32'd0);
    check("bus_addr_hold", bus_addr, addr);
    // A request offered during the response cycle must not be captured.
    cpu_valid = 1'b1;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    cpu_instr = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    cpu_wstrb = 4'h0;
    check("resp_cpu_ready_drop", 32'(cpu_ready), 32'd0);
    check("resp_event_drop", 32'(timeout_event), 32'd0);
    check("resp_no_capture", 32'(bus_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    cpu_valid = 1'b1;
    cpu_instr = 1'b1;
    cpu_addr  = 32'h0000_1234;
    cpu_wdata = 32'hffff_ffff;
    cpu_wstrb = 4'hf;
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
    err_clear = 1'b0;

    repeat (3) begin
      @(posedge clk); #1;
      check("rst_bus_valid", 32'(bus_valid), 32'd0);
      check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    end
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_bus_wstrb", 32'(bus_wstrb), 32'h0);
    check("rst_bus_instr", 32'(bus_instr), 32'h0);
    check("rst_timeout_event", 32'(timeout_event), 32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    check("rst_err_instr", 32'(err_instr), 32'h0);
    reset     = 1'b0;
    cpu_valid = 1'b0;
    cpu_instr = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    cpu_wstrb = 4'h0;
    @(posedge clk); #1;
    check("post_rst_idle", 32'(bus_valid), 32'd0);

    access(1'b0, 32'h4000_0010, 32'h0, 4'b0000, 1, 32'hdead_beef, 0);
    access(1'b0, 32'h4000_0020, 32'h1234_5678, 4'b0011, 3, 32'h0000_0000, 0);

    access(1'b1, 32'hc500_0000, 32'h0, 4'b0000, 0, 32'h0, 0);
    check("tmo_err_count", 32'(err_count), 32'd1);
    check("tmo_err_addr", err_addr, 32'hc500_0000);
    check("tmo_err_instr", 32'(err_instr), 32'd1);
    bus_ready = 1'b1;
    bus_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    check("late_ready_cpu_ready", 32'(cpu_ready), 32'd0);
    check("late_ready_bus_valid", 32'(bus_valid), 32'd0);
    check("late_ready_err_count", 32'(err_count), 32'd1);

    access(1'b0, 32'h4000_0030, 32'h0, 4'b0000, int'(T), 32'ha5a5_a5a5, 0);
    check("race_err_count", 32'(err_count), 32'd1);
    check("race_err_addr", err_addr, 32'hc500_0000);

    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    check("clear_err_count", 32'(err_count), 32'd0);
    check("clear_err_addr", err_addr, 32'h0);

    for (int i = 0; i < 300; i++) begin
      access(1'(i), 32'h8000_0000 + 32'(i) * 32'd4, 32'h0, 4'b0000, 0, 32'h0, 0);
      if (i == 254) check("sat_reach_255", 32'(err_count), 32'd255);
    end
    check("sat_err_count", 32'(err_count), 32'd255);
    check("sat_err_addr", err_addr, 32'h8000_0000 + 32'd299 * 32'd4);
    check("sat_err_instr", 32'(err_instr), 32'd1);

    access(1'b0, 32'h9000_0004, 32'h0, 4'b0000, 0, 32'h0, int'(T));
    check("clr_tmo_err_count", 32'(err_count), 32'd1);
    check("clr_tmo_err_addr", err_addr, 32'h9000_0004);
    check("clr_tmo_err_instr", 32'(err_instr), 32'd0);

    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    check("clear2_err_count", 32'(err_count), 32'd0);
    check("clear2_err_addr", err_addr, 32'h0);

    // Reset in the middle of WAIT abandons the request without a response.
    cpu_valid = 1'b1;
    cpu_addr  = 32'h7000_0000;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    check("midwait_bus_valid", 32'(bus_valid), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midwait_rst_bus_valid", 32'(bus_valid), 32'd0);
    check("midwait_rst_bus_addr", bus_addr, 32'h0);
    repeat (T + 2) begin
      @(posedge clk); #1;
    end
    check("midwait_no_resp", 32'(cpu_ready), 32'd0);
    check("midwait_idle", 32'(bus_valid), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
